// File: rtl/rv32i_trap_controller.sv
// rv32i_trap_controller: arbitrates interrupts/exceptions/mret at commit and
// sequences CSR strobes, flush and fetch redirect for trap entry and return.
`default_nettype none

module rv32i_trap_controller #(
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_is_illegal,
    input  logic        i_is_ecall,
    input  logic        i_is_ebreak,
    input  logic        i_is_mret,
    input  logic        i_ext_irq,
    input  logic        i_sw_irq,
    input  logic        i_tmr_irq,
    input  logic        i_mstatus_mie,
    input  logic [31:0] i_mie,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_stall,
    output logic        o_flush,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_mepc_we,
    output logic [31:0] o_mepc,
    output logic        o_mcause_we,
    output logic [31:0] o_mcause,
    output logic        o_mtval_we,
    output logic [31:0] o_mtval,
    output logic        o_mstatus_trap,
    output logic        o_mstatus_mret,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SAVE = 2'd1,
        S_JUMP = 2'd2,
        S_RET  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] tval_q,  tval_d;

    logic        irq_ext, irq_sw, irq_tmr;
    logic        evt_trap;
    logic [31:0] evt_cause;
    logic [31:0] evt_tval;
    logic        qualified;
    logic [31:0] trap_base;
    logic        unused_ok;

    assign irq_ext = i_ext_irq & i_mie[11] & i_mstatus_mie;
    assign irq_sw  = i_sw_irq  & i_mie[3]  & i_mstatus_mie;
    assign irq_tmr = i_tmr_irq & i_mie[7]  & i_mstatus_mie;

    // Reset gates qualification so the combinational stall is also 0 in reset.
    assign qualified = i_rst_n & i_valid & (state_q == S_IDLE);

    assign unused_ok = ^{i_mie[31:12], i_mie[10:8], i_mie[6:4], i_mie[2:0], i_mepc[1:0]};

    always_comb begin
        evt_trap  = 1'b1;
        evt_cause = 32'h0;
        evt_tval  = 32'h0;
        if (irq_ext)           evt_cause = 32'h8000_000B;
        else if (irq_sw)       evt_cause = 32'h8000_0003;
        else if (irq_tmr)      evt_cause = 32'h8000_0007;
        else if (i_is_illegal) begin
            evt_cause = 32'h0000_0002;
            evt_tval  = i_instr;
        end
        else if (i_is_ecall)   evt_cause = 32'h0000_000B;
        else if (i_is_ebreak) begin
            evt_cause = 32'h0000_0003;
            evt_tval  = i_pc;
        end
        else                   evt_trap = 1'b0;
    end

    // Vectored offset is 4*cause[30:0]; bits above 31 drop out (mod 2^32).
    always_comb begin
        trap_base = {i_mtvec[31:2], 2'b00};
        if (VECTORED_EN && (i_mtvec[1:0] == 2'b01) && cause_q[31])
            trap_base = {i_mtvec[31:2], 2'b00} + {cause_q[29:0], 2'b00};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cause_q <= 32'h0;
            pc_q    <= 32'h0;
            tval_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            tval_q  <= tval_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cause_d          = cause_q;
        pc_d             = pc_q;
        tval_d           = tval_q;
        o_stall          = 1'b0;
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = 32'h0;
        o_mepc_we        = 1'b0;
        o_mcause_we      = 1'b0;
        o_mtval_we       = 1'b0;
        o_mstatus_trap   = 1'b0;
        o_mstatus_mret   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (qualified && evt_trap) begin
                    state_d = S_SAVE;
                    cause_d = evt_cause;
                    pc_d    = i_pc;
                    tval_d  = evt_tval;
                    o_stall = 1'b1;
                end else if (qualified && i_is_mret) begin
                    state_d = S_RET;
                    o_stall = 1'b1;
                end
            end
            S_SAVE: begin
                o_stall        = 1'b1;
                o_flush        = 1'b1;
                o_mepc_we      = 1'b1;
                o_mcause_we    = 1'b1;
                o_mtval_we     = 1'b1;
                o_mstatus_trap = 1'b1;
                state_d        = S_JUMP;
            end
            S_JUMP: begin
                o_stall          = 1'b1;
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = trap_base;
                state_d          = S_IDLE;
            end
            S_RET: begin
                o_stall          = 1'b1;
                o_flush          = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = {i_mepc[31:2], 2'b00};
                o_mstatus_mret   = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_mepc   = pc_q;
    assign o_mcause = cause_q;
    assign o_mtval  = tval_q;
    assign o_busy   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rv32i_trap_controller.sv
// Directed vector bench for rv32i_trap_controller.
`default_nettype none

module tb_rv32i_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ill, ecall, ebrk, mret, ext, sw, tmr, gmie;
    logic [31:0] pc, instr, mie, mtvec, mepc;
    logic        stall, flush, rv, mepc_we, mcause_we, mtval_we, st_trap, st_mret, busy;
    logic [31:0] rpc, o_mepc, o_mcause, o_mtval;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rv32i_trap_controller #(.VECTORED_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc), .i_instr(instr),
        .i_is_illegal(ill), .i_is_ecall(ecall), .i_is_ebreak(ebrk), .i_is_mret(mret),
        .i_ext_irq(ext), .i_sw_irq(sw), .i_tmr_irq(tmr), .i_mstatus_mie(gmie),
        .i_mie(mie), .i_mtvec(mtvec), .i_mepc(mepc),
        .o_stall(stall), .o_flush(flush), .o_redirect_valid(rv), .o_redirect_pc(rpc),
        .o_mepc_we(mepc_we), .o_mepc(o_mepc), .o_mcause_we(mcause_we), .o_mcause(o_mcause),
        .o_mtval_we(mtval_we), .o_mtval(o_mtval), .o_mstatus_trap(st_trap),
        .o_mstatus_mret(st_mret), .o_busy(busy)
    );

    // kind: 0 = no event, 1 = trap, 2 = mret
    typedef struct {
        logic        valid, ext, sw, tmr, gmie;
        logic [31:0] mie;
        logic        ill, ecall, ebrk, mret;
        logic [31:0] pc, instr, mtvec, mepc;
        int          kind;
        logic [31:0] cause, tval, rpc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic clear_events();
        valid = 0; ext = 0; sw = 0; tmr = 0; ill = 0; ecall = 0; ebrk = 0; mret = 0;
    endtask

    task automatic apply(input vec_t v);
        valid = v.valid; ext = v.ext; sw = v.sw; tmr = v.tmr; gmie = v.gmie; mie = v.mie;
        ill = v.ill; ecall = v.ecall; ebrk = v.ebrk; mret = v.mret;
        pc = v.pc; instr = v.instr; mtvec = v.mtvec; mepc = v.mepc;
    endtask

    initial begin
        vecs[0] = '{1,0,0,0,0, 32'h0,   1,0,0,0, 32'h100, 32'hFFFF_FFFF, 32'h200,  32'h0,   1, 32'h2,         32'hFFFF_FFFF, 32'h200};
        vecs[1] = '{1,0,0,1,1, 32'h80,  0,0,0,0, 32'h40,  32'h13,        32'h1001, 32'h0,   1, 32'h8000_0007, 32'h0,         32'h101C};
        vecs[2] = '{1,1,1,0,1, 32'h808, 0,1,0,0, 32'h300, 32'h73,        32'h1001, 32'h0,   1, 32'h8000_000B, 32'h0,         32'h102C};
        vecs[3] = '{1,1,1,0,0, 32'h808, 0,1,0,0, 32'h300, 32'h73,        32'h1001, 32'h0,   1, 32'h0000_000B, 32'h0,         32'h1000};
        vecs[4] = '{1,0,0,0,1, 32'h0,   0,0,0,1, 32'h400, 32'h3020_0073, 32'h200,  32'h123, 2, 32'h0,         32'h0,         32'h120};
        vecs[5] = '{1,1,0,0,1, 32'h0,   0,0,1,0, 32'h80,  32'h0010_0073, 32'h200,  32'h0,   1, 32'h3,         32'h80,        32'h200};
        vecs[6] = '{0,1,1,1,1, 32'hFFFF_FFFF, 1,1,1,1, 32'h500, 32'hBAD, 32'h200,  32'h44,  0, 32'h0,         32'h0,         32'h0};
        vecs[7] = '{1,0,1,0,1, 32'h8,   0,0,0,0, 32'h60,  32'h13,        32'hFFFF_FFFD, 32'h0, 1, 32'h8000_0003, 32'h0,       32'h8};
        vecs[8] = '{1,0,0,0,1, 32'h0,   1,0,0,1, 32'h70,  32'hABCD_1234, 32'h204,  32'h88,  1, 32'h2,         32'hABCD_1234, 32'h204};
        vecs[9] = '{1,0,0,1,1, 32'h0,   0,1,1,1, 32'h90,  32'h73,        32'h300,  32'h88,  1, 32'hB,         32'h0,         32'h300};

        rst_n = 0; clear_events(); gmie = 0; pc = 0; instr = 0; mie = 0; mtvec = 0; mepc = 0;
        #1;
        chk("reset_ctrl", {31'h0, stall|flush|rv|mepc_we|mcause_we|mtval_we|st_trap|st_mret|busy}, 32'h0);
        chk("reset_data", o_mepc | o_mcause | o_mtval | rpc, 32'h0);
        @(negedge clk); rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d_detect_stall", i), {31'h0, stall}, {31'h0, vecs[i].kind != 0});
            @(posedge clk); #1;
            if (vecs[i].kind == 1) begin
                chk($sformatf("v%0d_save_strobes", i),
                    {26'h0, mepc_we, mcause_we, mtval_we, st_trap, flush, stall}, 32'h3F);
                chk($sformatf("v%0d_save_quiet", i), {29'h0, rv, st_mret, ~busy}, 32'h0);
                chk($sformatf("v%0d_mcause", i), o_mcause, vecs[i].cause);
                chk($sformatf("v%0d_mepc", i), o_mepc, vecs[i].pc);
                chk($sformatf("v%0d_mtval", i), o_mtval, vecs[i].tval);
                @(posedge clk); #1;
                chk($sformatf("v%0d_jump_ctrl", i),
                    {26'h0, rv, flush, stall, mepc_we, st_trap, mcause_we}, 32'h38);
                chk($sformatf("v%0d_redirect_pc", i), rpc, vecs[i].rpc);
                clear_events();
            end else if (vecs[i].kind == 2) begin
                chk($sformatf("v%0d_ret_ctrl", i),
                    {25'h0, st_mret, flush, rv, stall, mepc_we, mcause_we, mtval_we}, 32'h78);
                chk($sformatf("v%0d_ret_trap", i), {31'h0, st_trap}, 32'h0);
                chk($sformatf("v%0d_redirect_pc", i), rpc, vecs[i].rpc);
                clear_events();
            end else begin
                chk($sformatf("v%0d_no_strobes", i),
                    {23'h0, mepc_we, mcause_we, mtval_we, st_trap, st_mret, flush, rv, busy, stall}, 32'h0);
                clear_events();
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_idle", i), {29'h0, busy, stall, rv}, 32'h0);
        end

        // Reset asserted while in SAVE, event inputs still held.
        @(negedge clk);
        apply(vecs[0]);
        pc = 32'h500;
        @(posedge clk); #1;
        chk("rst_mid_save_entered", {31'h0, mepc_we}, 32'h1);
        rst_n = 0; #1;
        chk("rst_mid_ctrl", {31'h0, stall|flush|rv|mepc_we|mcause_we|mtval_we|st_trap|st_mret|busy}, 32'h0);
        chk("rst_mid_data", o_mepc | o_mcause | o_mtval | rpc, 32'h0);
        clear_events();
        @(negedge clk); rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_after_%0d", k), {30'h0, rv, busy}, 32'h0);
        end

        // New event taken normally after the aborted sequence.
        @(negedge clk);
        valid = 1; ecall = 1; pc = 32'h600; mtvec = 32'h800;
        #1;
        chk("post_rst_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        chk("post_rst_mcause", o_mcause, 32'hB);
        chk("post_rst_mepc", o_mepc, 32'h600);
        @(posedge clk); #1;
        chk("post_rst_redirect", {31'h0, rv}, 32'h1);
        chk("post_rst_rpc", rpc, 32'h800);
        clear_events();
        @(posedge clk); #1;
        chk("post_rst_idle", {31'h0, busy}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
